// File: rtl/od_multi_trig_gen.sv
// Multi-channel ultrasonic trigger sequencer: walks the latched channel mask one
// slot at a time, pulsing each enabled trigger and then waiting out its echo guard.
//
// state | meaning
// IDLE  | no frame in progress, waiting for en/mask/mode/start
// PULSE | trig[active_ch] high, counter 0 .. PULSE_CYC-1
// GUARD | trig low, echo guard, counter PULSE_CYC .. SLOT_CYC-1
module od_multi_trig_gen #(
   parameter int N_CH      = 4,
   parameter int CNT_W     = 24,
   parameter int PULSE_CYC = 1000,
   parameter int SLOT_CYC  = 5_000_000,
   localparam int AW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            mode,
   input  logic            start,
   input  logic [N_CH-1:0] ch_mask,
   output logic [N_CH-1:0] trig,
   output logic [AW-1:0]   active_ch,
   output logic            busy,
   output logic            frame_done
);

   if (!(PULSE_CYC >= 1 && PULSE_CYC < SLOT_CYC &&
         longint'(SLOT_CYC) <= (longint'(1) << CNT_W))) begin : g_bad_param
      $error("od_multi_trig_gen: need 1 <= PULSE_CYC < SLOT_CYC <= 2**CNT_W");
   end

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GUARD} state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [N_CH-1:0]   r_mask, w_mask_nxt;
   logic [N_CH-1:0]   r_trig, w_trig_nxt;
   logic              r_mode, w_mode_nxt;
   logic [AW-1:0]     r_ch, w_ch_nxt;
   logic [AW-1:0]     w_first_ch, w_next_ch;
   logic              w_has_next, w_pulse_end, w_slot_end, w_can_start;

   always_comb begin
      w_first_ch = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) w_first_ch = AW'(i);
      end
   end

   // Next higher enabled channel of the frame copy, above the one in its slot now.
   always_comb begin
      w_has_next = 1'b0;
      w_next_ch  = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (r_mask[i] && (i > int'(r_ch))) begin
            w_has_next = 1'b1;
            w_next_ch  = AW'(i);
         end
      end
   end

   assign w_pulse_end = (r_state == S_PULSE) && (r_cnt == CNT_W'(PULSE_CYC - 1));
   assign w_slot_end  = (r_state == S_GUARD) && (r_cnt == CNT_W'(SLOT_CYC - 1));
   assign w_can_start = en && (ch_mask != '0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mask_nxt  = r_mask;
      w_mode_nxt  = r_mode;
      w_ch_nxt    = r_ch;
      w_trig_nxt  = '0;
      if (!en) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_can_start && (!mode || start)) begin
                  w_state_nxt          = S_PULSE;
                  w_mask_nxt           = ch_mask;
                  w_mode_nxt           = mode;
                  w_ch_nxt             = w_first_ch;
                  w_cnt_nxt            = '0;
                  w_trig_nxt[w_first_ch] = 1'b1;
               end
            end
            S_PULSE: begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (w_pulse_end) w_state_nxt = S_GUARD;
               else             w_trig_nxt[r_ch] = 1'b1;
            end
            S_GUARD: begin
               if (!w_slot_end) begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end else if (w_has_next) begin
                  w_state_nxt           = S_PULSE;
                  w_ch_nxt              = w_next_ch;
                  w_cnt_nxt             = '0;
                  w_trig_nxt[w_next_ch] = 1'b1;
               end else if (!r_mode && w_can_start) begin
                  // Periodic scan rolls straight into the next frame, re-latching inputs.
                  w_state_nxt            = S_PULSE;
                  w_mask_nxt             = ch_mask;
                  w_mode_nxt             = mode;
                  w_ch_nxt               = w_first_ch;
                  w_cnt_nxt              = '0;
                  w_trig_nxt[w_first_ch] = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_mask  <= '0;
         r_mode  <= 1'b0;
         r_ch    <= '0;
         r_trig  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mask  <= w_mask_nxt;
         r_mode  <= w_mode_nxt;
         r_ch    <= w_ch_nxt;
         r_trig  <= w_trig_nxt;
      end
   end

   // Gated by en so an abort on the final guard cycle never reports a finished frame.
   assign frame_done = w_slot_end && !w_has_next && en;
   assign trig       = r_trig;
   assign active_ch  = r_ch;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_od_multi_trig_gen.sv
// Directed bench for od_multi_trig_gen with a slot-schedule reference model
// checked every cycle, plus hand-computed timing expectations per scenario.
module tb_od_multi_trig_gen;

   localparam int N_CH  = 4;
   localparam int PULSE = 4;
   localparam int SLOT  = 10;

   logic            clk;
   logic            rst_n;
   logic            en;
   logic            mode;
   logic            start;
   logic [N_CH-1:0] ch_mask;
   logic [N_CH-1:0] trig;
   logic [1:0]      active_ch;
   logic            busy;
   logic            frame_done;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   od_multi_trig_gen #(
      .N_CH(N_CH), .CNT_W(8), .PULSE_CYC(PULSE), .SLOT_CYC(SLOT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
      .ch_mask(ch_mask), .trig(trig), .active_ch(active_ch), .busy(busy),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Reference model: a frame is the ascending list of enabled channels, each
   // owning SLOT cycles whose first PULSE cycles carry the trigger.
   bit  m_busy = 1'b0;
   bit  m_mode = 1'b0;
   int  m_ch   = 0;
   int  m_t    = 0;
   int  rem[$];

   task automatic new_frame();
      m_mode = mode;
      rem.delete();
      for (int i = 0; i < N_CH; i++) if (ch_mask[i]) rem.push_back(i);
      m_ch   = rem.pop_front();
      m_t    = 0;
      m_busy = 1'b1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_ch   = 0;
         m_t    = 0;
         rem.delete();
      end else if (!en) begin
         m_busy = 1'b0;
      end else if (!m_busy) begin
         if (ch_mask != '0 && (!mode || start)) new_frame();
      end else if (m_t == SLOT - 1) begin
         if (rem.size() > 0) begin
            m_ch = rem.pop_front();
            m_t  = 0;
         end else if (!m_mode && ch_mask != '0) begin
            new_frame();
         end else begin
            m_busy = 1'b0;
         end
      end else begin
         m_t++;
      end
   end

   // Per-cycle compare plus event log for the literal timing checks.
   int rise_t[N_CH][8];
   int rise_n[N_CH];
   int fd_n, fd_first;
   logic [N_CH-1:0] prev_trig = '0;

   task automatic clr();
      for (int c = 0; c < N_CH; c++) rise_n[c] = 0;
      fd_n     = 0;
      fd_first = -1;
   endtask

   always @(posedge clk) begin
      logic [N_CH-1:0] e_trig;
      #1;
      e_trig = (m_busy && m_t < PULSE) ? (N_CH'(1) << m_ch) : '0;
      chk("trig", 32'(trig), 32'(e_trig));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("frame_done", 32'(frame_done),
          32'(m_busy && m_t == SLOT - 1 && rem.size() == 0 && en));
      if (m_busy) chk("active_ch", 32'(active_ch), 32'(m_ch));
      for (int c = 0; c < N_CH; c++) begin
         if (trig[c] && !prev_trig[c]) begin
            if (rise_n[c] < 8) rise_t[c][rise_n[c]] = cyc;
            rise_n[c]++;
         end
      end
      if (frame_done) begin
         if (fd_n == 0) fd_first = cyc;
         fd_n++;
      end
      prev_trig = trig;
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   int t0;

   initial begin
      clr();
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0; ch_mask = '0;
      wait_n(3);
      chk("reset_trig", 32'(trig), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_active_ch", 32'(active_ch), 32'd0);
      chk("reset_frame_done", 32'(frame_done), 32'd0);
      rst_n = 1'b1;
      wait_n(2);

      // en with empty mask holds idle
      en = 1'b1;
      wait_n(3);
      chk("empty_mask_busy", 32'(busy), 32'd0);

      // periodic scan, all channels
      clr(); ch_mask = 4'b1111; t0 = cyc;
      wait_n(85);
      chk("p1111_first_rise", 32'(rise_t[0][0]), 32'(t0 + 1));
      chk("p1111_ch1_gap", 32'(rise_t[1][0] - rise_t[0][0]), 32'd10);
      chk("p1111_ch3_gap", 32'(rise_t[3][0] - rise_t[0][0]), 32'd30);
      chk("p1111_ch0_period", 32'(rise_t[0][1] - rise_t[0][0]), 32'd40);
      chk("p1111_ch0_rises", 32'(rise_n[0]), 32'd3);
      chk("p1111_fd_first", 32'(fd_first), 32'(t0 + 40));
      chk("p1111_fd_count", 32'(fd_n), 32'd2);

      // sparse mask
      en = 1'b0; wait_n(2);
      clr(); ch_mask = 4'b1010; en = 1'b1; t0 = cyc;
      wait_n(45);
      chk("p1010_ch0_quiet", 32'(rise_n[0]), 32'd0);
      chk("p1010_ch2_quiet", 32'(rise_n[2]), 32'd0);
      chk("p1010_ch1_first", 32'(rise_t[1][0]), 32'(t0 + 1));
      chk("p1010_ch3_gap", 32'(rise_t[3][0] - rise_t[1][0]), 32'd10);
      chk("p1010_period", 32'(rise_t[1][1] - rise_t[1][0]), 32'd20);

      // one-shot frame, with a start pulse mid-frame
      en = 1'b0; wait_n(2);
      clr(); mode = 1'b1; ch_mask = 4'b0110; en = 1'b1; start = 1'b1; t0 = cyc;
      wait_n(1); start = 1'b0;
      wait_n(11); start = 1'b1;
      wait_n(1); start = 1'b0;
      wait_n(27);
      chk("os_ch1_rises", 32'(rise_n[1]), 32'd1);
      chk("os_ch2_rises", 32'(rise_n[2]), 32'd1);
      chk("os_ch2_rise", 32'(rise_t[2][0]), 32'(t0 + 11));
      chk("os_fd_count", 32'(fd_n), 32'd1);
      chk("os_fd_cycle", 32'(fd_first), 32'(t0 + 20));
      chk("os_busy_after", 32'(busy), 32'd0);

      // abort while trig[2] is high, then restart
      en = 1'b0; wait_n(2);
      clr(); mode = 1'b0; ch_mask = 4'b1111; en = 1'b1; t0 = cyc;
      wait_n(22);
      chk("abort_pre_trig", 32'(trig), 32'b0100);
      en = 1'b0;
      wait_n(1);
      chk("abort_trig", 32'(trig), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_no_fd", 32'(fd_n), 32'd0);
      en = 1'b1;
      wait_n(1);
      chk("restart_trig", 32'(trig), 32'b0001);

      // mask change mid-frame only takes effect next frame
      en = 1'b0; wait_n(2);
      clr(); ch_mask = 4'b1111; en = 1'b1; t0 = cyc;
      wait_n(15); ch_mask = 4'b0001;
      wait_n(55);
      chk("mchg_ch3_rises", 32'(rise_n[3]), 32'd1);
      chk("mchg_ch0_rises", 32'(rise_n[0]), 32'd4);
      chk("mchg_new_start", 32'(rise_t[0][1]), 32'(t0 + 41));
      chk("mchg_new_period", 32'(rise_t[0][2] - rise_t[0][1]), 32'd10);

      // reset mid-guard of channel 1
      en = 1'b0; wait_n(2);
      clr(); ch_mask = 4'b1111; en = 1'b1; t0 = cyc;
      wait_n(16);
      chk("pre_reset_active_ch", 32'(active_ch), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_trig", 32'(trig), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_active_ch", 32'(active_ch), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      en = 1'b0;
      wait_n(2);
      rst_n = 1'b1;
      wait_n(3);
      chk("post_reset_busy", 32'(busy), 32'd0);
      chk("post_reset_trig", 32'(trig), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/od_multi_trig_gen.md
OD_MULTI_TRIG_GEN -- requirements
Module: od_multi_trig_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of ultrasonic trigger channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 24, width of the slot timer.
REQ-003 SHALL have parameter PULSE_CYC, default 1000, trigger high time in clk cycles (20 us at 50 MHz).
REQ-004 SHALL have parameter SLOT_CYC, default 5_000_000, cycles per channel slot, pulse plus echo guard (100 ms at 50 MHz).
REQ-005 SHALL have port clk, input, 1, the single system clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port en, input, 1, global scan enable.
REQ-008 SHALL have port mode, input, 1: 0 = periodic scan, 1 = one-shot frame.
REQ-009 SHALL have port start, input, 1, one-shot frame request, level-sampled.
REQ-010 SHALL have port ch_mask, input, N_CH, per-channel enable.
REQ-011 SHALL have port trig, output, N_CH, registered trigger pulses, at most one bit high.
REQ-012 SHALL have port active_ch, output, $clog2(N_CH) (min 1), index of the channel owning the current slot.
REQ-013 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse at the end of each frame.

Function
REQ-015 SHALL implement FSM states IDLE, PULSE and GUARD with one CNT_W-bit slot counter.
REQ-016 SHALL require 1 <= PULSE_CYC < SLOT_CYC <= 2^CNT_W; a violation is an elaboration error.
REQ-017 IDLE->PULSE SHALL occur on an edge where en=1, ch_mask!=0, and either mode=0 or start=1.
REQ-018 On IDLE->PULSE, SHALL latch ch_mask and mode into internal frame copies; mid-frame input changes SHALL NOT affect the current frame.
REQ-019 On IDLE->PULSE, SHALL select the lowest-index set bit of the latched mask as active_ch and clear the counter.
REQ-020 trig[active_ch] SHALL be high for exactly PULSE_CYC consecutive cycles, beginning the cycle after the PULSE entry edge.
REQ-021 PULSE->GUARD SHALL occur when counter = PULSE_CYC-1; trig SHALL be all-zero in GUARD.
REQ-022 GUARD SHALL last until counter = SLOT_CYC-1, so consecutive trigger rising edges are exactly SLOT_CYC cycles apart.
REQ-023 At the end of GUARD, SHALL advance to the next higher set bit of the latched mask, skipping cleared channels, clear the counter and re-enter PULSE.
REQ-024 If no higher set bit exists, SHALL assert frame_done during the final GUARD cycle.
REQ-025 After frame_done in periodic mode with en=1 and ch_mask!=0, SHALL re-latch and restart from the lowest channel with no idle gap.
REQ-026 After frame_done in one-shot mode, or when ch_mask=0, SHALL return to IDLE.
REQ-027 Frame period SHALL be SLOT_CYC x popcount(latched mask) cycles.
REQ-028 en=0 in any state SHALL abort: on the next edge trig=0, go to IDLE, clear the counter, and not assert frame_done.
REQ-029 start while busy SHALL be ignored and not queued.
REQ-030 ch_mask=0 with en=1 SHALL hold IDLE with busy=0.
REQ-031 The counter SHALL never wrap; it is cleared only at a slot end or on abort.
REQ-032 For N_CH=1, active_ch SHALL be constant 0 and frames SHALL equal one slot.

Reset
REQ-033 While rst_n=0, SHALL hold trig=0, active_ch=0, busy=0, frame_done=0, counter=0, state=IDLE, and latched mask=0.
REQ-034 Reset assertion mid-pulse SHALL drop trig asynchronously; after release, operation SHALL begin only per REQ-017.

Verification (N_CH=4, PULSE_CYC=4, SLOT_CYC=10)
REQ-035 Periodic mode, mask=4'b1111, en rises -> trig[0..3] each high 4 cycles, rises 10 cycles apart; frame_done every 40 cycles; trig[0] again 40 cycles after its first rise.
REQ-036 Mask=4'b1010 -> only trig[1] then trig[3] fire, 10 cycles apart; period 20; trig[0] and trig[2] stay 0.
REQ-037 One-shot mode, start held 1 cycle with mask=4'b0110 -> trig[1] then trig[2], one frame_done, busy low thereafter; a start pulse mid-frame has no effect.
REQ-038 en dropped during trig[2] high -> trig=0 and busy=0 after one edge, no frame_done; en re-raised -> restarts at channel 0.
REQ-039 Mask changed from 4'b1111 to 4'b0001 mid-frame -> current frame completes all 4 channels; next frame fires only trig[0], period 10.
REQ-040 rst_n pulsed low mid-GUARD -> all outputs 0 immediately; state IDLE on release.
